// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and state encoding for the 8x32 FIFO control stage.
//   FIFO_AW    : pointer width in bits
//   FIFO_DEPTH : number of entries (1 << FIFO_AW)
//   state_e    : operation state, also exported on the debug state port
package fifo_pkg;

  localparam int FIFO_AW    = 3;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5
  } state_e;

endpackage

// File: rtl/fifo_wr_dec.sv
// fifo_wr_dec: one-hot write-enable decoder for the FIFO register bank.
// Ports:
//   tail_i : slot index to be written
//   en_i   : write accepted this cycle
//   we_o   : one-hot enable, bit tail_i set when en_i, otherwise all zero
module fifo_wr_dec
  import fifo_pkg::*;
#(
  parameter int AW    = FIFO_AW,
  parameter int DEPTH = 1 << AW
) (
  input  logic [AW-1:0]    tail_i,
  input  logic             en_i,
  output logic [DEPTH-1:0] we_o
);

  // Decode the tail index into a single enable bit when the write is accepted.
  always_comb begin
    we_o = '0;
    if (en_i) begin
      we_o[tail_i] = 1'b1;
    end else begin
      we_o = '0;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: head/tail pointers, occupancy count and operation state machine
// for the 8-entry x 32-bit FIFO.
// Ports:
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   wr_en, rd_en        : write / read requests, sampled every cycle
//   we                  : one-hot write enable into the register bank (comb)
//   wr_ptr, rd_ptr      : tail index / head index (read-mux select)
//   rd_fire             : read accepted this cycle, load strobe for dout (comb)
//   full, empty         : occupancy status, derived from the count only
//   data_count          : occupancy 0..DEPTH
//   wr_ack/wr_err       : previous-cycle write accepted / rejected
//   rd_ack/rd_err       : previous-cycle read accepted / rejected
//   state               : current state, for debug
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int AW    = FIFO_AW,
  parameter int DEPTH = 1 << AW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [DEPTH-1:0] we,
  output logic [AW-1:0]    wr_ptr,
  output logic [AW-1:0]    rd_ptr,
  output logic             rd_fire,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      data_count,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err,
  output logic [2:0]       state
);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;

  logic wr_req_only, rd_req_only;
  logic wr_acc, wr_rej, rd_acc, rd_rej;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  // Simultaneous wr_en & rd_en is a no-op, so each side only counts alone.
  // reset_n gates acceptance so we/rd_fire drop immediately on reset even
  // though the request inputs may still be high.
  assign wr_req_only = wr_en & ~rd_en;
  assign rd_req_only = rd_en & ~wr_en;
  assign wr_acc = reset_n & wr_req_only & ~full;
  assign wr_rej = reset_n & wr_req_only &  full;
  assign rd_acc = reset_n & rd_req_only & ~empty;
  assign rd_rej = reset_n & rd_req_only &  empty;

  assign rd_fire = rd_acc;

  fifo_wr_dec #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_wr_dec (
    .tail_i (tail_q),
    .en_i   (wr_acc),
    .we_o   (we)
  );

  // Next pointers, count and state from this cycle's request classification.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = NO_OP;
    if (wr_acc) begin
      tail_d  = tail_q + {{(AW-1){1'b0}}, 1'b1};
      count_d = count_q + {{AW{1'b0}}, 1'b1};
      state_d = WRITE;
    end else if (wr_rej) begin
      state_d = WR_ERROR;
    end else if (rd_acc) begin
      head_d  = head_q + {{(AW-1){1'b0}}, 1'b1};
      count_d = count_q - {{AW{1'b0}}, 1'b1};
      state_d = READ;
    end else if (rd_rej) begin
      state_d = RD_ERROR;
    end else begin
      state_d = NO_OP;
    end
  end

  // State, pointer and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= INIT;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign wr_ptr     = tail_q;
  assign rd_ptr     = head_q;
  assign data_count = count_q;
  assign state      = state_q;

  // Handshake strobes are decoded straight from the registered state.
  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    rd_ack = 1'b0;
    rd_err = 1'b0;
    case (state_q)
      WRITE:    wr_ack = 1'b1;
      WR_ERROR: wr_err = 1'b1;
      READ:     rd_ack = 1'b1;
      RD_ERROR: rd_err = 1'b1;
      default: begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        rd_ack = 1'b0;
        rd_err = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl.
module tb_fifo_ctrl;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] we;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic       rd_fire;
  logic       full;
  logic       empty;
  logic [3:0] data_count;
  logic       wr_ack;
  logic       wr_err;
  logic       rd_ack;
  logic       rd_err;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  fifo_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .we         (we),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .rd_fire    (rd_fire),
    .full       (full),
    .empty      (empty),
    .data_count (data_count),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  task automatic do_writes(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b0;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_reads(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if ({empty, full, data_count, we, state, wr_ack, wr_err, rd_ack, rd_err, rd_fire}
        !== {1'b1, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got empty=%b full=%b cnt=%0d we=%h st=%0d acks=%b%b%b%b fire=%b expected 1 0 0 00 0 0000 0",
               empty, full, data_count, we, state, wr_ack, wr_err, rd_ack, rd_err, rd_fire);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL idle_state: got %0d expected 1", state);
    end
    tick();
    tick();
    checks++;
    if ({empty, full, data_count, we, state} !== {1'b1, 1'b0, 4'd0, 8'h00, 3'd1}) begin
      errors++;
      $display("FAIL idle_status: got empty=%b full=%b cnt=%0d we=%h st=%0d expected 1 0 0 00 1",
               empty, full, data_count, we, state);
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_we;
    for (int i = 0; i < 8; i++) begin
      wr_en  = 1'b1;
      rd_en  = 1'b0;
      exp_we = 8'h01 << i;
      #1;
      checks++;
      if (we !== exp_we || wr_ptr !== 3'(i)) begin
        errors++;
        $display("FAIL fill_we[%0d]: got we=%h wr_ptr=%0d expected we=%h wr_ptr=%0d", i, we, wr_ptr, exp_we, i);
      end
      tick();
      checks++;
      if (wr_ack !== 1'b1 || data_count !== 4'(i + 1)) begin
        errors++;
        $display("FAIL fill_ack[%0d]: got ack=%b cnt=%0d expected ack=1 cnt=%0d", i, wr_ack, data_count, i + 1);
      end
    end
    checks++;
    if (full !== 1'b1 || empty !== 1'b0 || data_count !== 4'd8 || wr_ptr !== 3'd0) begin
      errors++;
      $display("FAIL fill_full: got full=%b empty=%b cnt=%0d wr_ptr=%0d expected 1 0 8 0", full, empty, data_count, wr_ptr);
    end
    wr_en = 1'b1;
    #1;
    checks++;
    if (we !== 8'h00) begin
      errors++;
      $display("FAIL overflow_we: got %h expected 00", we);
    end
    tick();
    wr_en = 1'b0;
    checks++;
    if (wr_err !== 1'b1 || wr_ack !== 1'b0 || data_count !== 4'd8 || wr_ptr !== 3'd0) begin
      errors++;
      $display("FAIL overflow_err: got err=%b ack=%b cnt=%0d wr_ptr=%0d expected 1 0 8 0", wr_err, wr_ack, data_count, wr_ptr);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b0;
      rd_en = 1'b1;
      #1;
      checks++;
      if (rd_fire !== 1'b1 || rd_ptr !== 3'(i)) begin
        errors++;
        $display("FAIL drain_fire[%0d]: got fire=%b rd_ptr=%0d expected fire=1 rd_ptr=%0d", i, rd_fire, rd_ptr, i);
      end
      tick();
      checks++;
      if (rd_ack !== 1'b1 || data_count !== 4'(7 - i)) begin
        errors++;
        $display("FAIL drain_ack[%0d]: got ack=%b cnt=%0d expected ack=1 cnt=%0d", i, rd_ack, data_count, 7 - i);
      end
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || rd_ptr !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: got empty=%b full=%b rd_ptr=%0d expected 1 0 0", empty, full, rd_ptr);
    end
    rd_en = 1'b1;
    #1;
    checks++;
    if (rd_fire !== 1'b0) begin
      errors++;
      $display("FAIL underflow_fire: got %b expected 0", rd_fire);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_err !== 1'b1 || rd_ack !== 1'b0 || rd_ptr !== 3'd0 || data_count !== 4'd0) begin
      errors++;
      $display("FAIL underflow_err: got err=%b ack=%b rd_ptr=%0d cnt=%0d expected 1 0 0 0", rd_err, rd_ack, rd_ptr, data_count);
    end
    tick();
    checks++;
    if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000 || state !== 3'd1) begin
      errors++;
      $display("FAIL strobe_clear: got acks=%b%b%b%b st=%0d expected 0000 1", wr_ack, wr_err, rd_ack, rd_err, state);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_tbl [5];
    exp_tbl[0] = 8'h20;
    exp_tbl[1] = 8'h40;
    exp_tbl[2] = 8'h80;
    exp_tbl[3] = 8'h01;
    exp_tbl[4] = 8'h02;
    apply_reset();
    tick();
    do_writes(5);
    do_reads(5);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      #1;
      checks++;
      if (we !== exp_tbl[i]) begin
        errors++;
        $display("FAIL wrap_we[%0d]: got %h expected %h", i, we, exp_tbl[i]);
      end
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (wr_ptr !== 3'd2 || rd_ptr !== 3'd5 || data_count !== 4'd5 || full !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL wrap_final: got wr_ptr=%0d rd_ptr=%0d cnt=%0d full=%b empty=%b expected 2 5 5 0 0",
               wr_ptr, rd_ptr, data_count, full, empty);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    tick();
    do_writes(3);
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    checks++;
    if (we !== 8'h00 || rd_fire !== 1'b0) begin
      errors++;
      $display("FAIL both_comb: got we=%h fire=%b expected 00 0", we, rd_fire);
    end
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    checks++;
    if (state !== 3'd1 || {wr_ack, wr_err, rd_ack, rd_err} !== 4'b0000 ||
        wr_ptr !== 3'd3 || rd_ptr !== 3'd0 || data_count !== 4'd3) begin
      errors++;
      $display("FAIL both_noop: got st=%0d acks=%b%b%b%b wr_ptr=%0d rd_ptr=%0d cnt=%0d expected 1 0000 3 0 3",
               state, wr_ack, wr_err, rd_ack, rd_err, wr_ptr, rd_ptr, data_count);
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    tick();
    do_writes(4);
    wr_en = 1'b1;
    #1;
    checks++;
    if (we !== 8'h10) begin
      errors++;
      $display("FAIL midrst_pre_we: got %h expected 10", we);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (we !== 8'h00 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0 || data_count !== 4'd0 ||
        empty !== 1'b1 || full !== 1'b0 || state !== 3'd0 || wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got we=%h wr_ptr=%0d rd_ptr=%0d cnt=%0d empty=%b full=%b st=%0d ack=%b expected 00 0 0 0 1 0 0 0",
               we, wr_ptr, rd_ptr, data_count, empty, full, state, wr_ack);
    end
    wr_en = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    checks++;
    if (data_count !== 4'd0 || state !== 3'd1) begin
      errors++;
      $display("FAIL midrst_after: got cnt=%0d st=%0d expected 0 1", data_count, state);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
